pcode_word_packer: RTL and testbench

- Sits directly downstream of the P-code chip generator.
- Collects the serial 1-bit P-code chip stream into WORD_WIDTH-bit words, MSB-first.
- Tags each word with a sequence number and buffers words in a small first-word-fall-through FIFO.
- Delivers words to the host/DMA side over a valid/ready handshake, and flags dropped words with a sticky overflow bit.

---
 rtl/pcode_pkg.sv | 21 ++
 rtl/pcode_word_fifo.sv | 70 +++++++
 rtl/pcode_word_packer.sv | 143 ++++++++++++++
 tb/tb_pcode_word_packer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcode_pkg.sv
// Shared definitions for the P-code chip path: packer FSM states and the
// default word geometry, kept in one place so the chip generator's parallel
// output and the word packer always agree on word and sequence widths.
package pcode_pkg;

  // Packer control states: IDLE ignores chips, PACK collects them into words.
  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } pack_state_t;

  // Default chips per packed word (also the generator's parallel-output width).
  localparam int DEFAULT_WORD_WIDTH = 32;

  // Default width of the per-word sequence counter.
  localparam int DEFAULT_SEQ_WIDTH  = 16;

  // Default number of buffered words between packer and host/DMA.
  localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/pcode_word_fifo.sv
// First-word-fall-through word buffer between the packer and the host side.
// The head entry is visible on pop_data combinationally while the FIFO is
// non-empty, and reads as zero when empty. A push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle; otherwise
// the word is refused and 'dropped' pulses for that cycle.
module pcode_word_fifo #(
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [LW-1:0]         level,
  output logic                  empty,
  output logic                  dropped
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic                  is_full;
  logic                  do_pop;
  logic                  do_push;

  // Qualify push/pop requests against occupancy, letting a same-cycle pop make room.
  always_comb begin
    is_full  = (count == LW'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!is_full || do_pop);
    dropped  = push && !do_push;
    level    = count;
    pop_data = empty ? '0 : mem[rd_ptr];
  end

  // Advance pointers and occupancy; reset discards every buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty reads are forced to zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pcode_word_packer.sv
// Collects the serial P-code chip stream into MSB-first words, tags each
// word with a wrapping sequence number and hands words to the host through
// a small FWFT buffer with a valid/ready handshake. Words that find the
// buffer full are dropped; the sequence counter still advances so the
// consumer sees a gap, and a sticky overflow flag records the loss.
module pcode_word_packer
  import pcode_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int SEQ_WIDTH  = DEFAULT_SEQ_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          chip_in,
  input  logic                          chip_vld,
  output logic [WORD_WIDTH-1:0]         word_data,
  output logic [SEQ_WIDTH-1:0]          word_seq,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic                          busy
);

  localparam int CW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
  localparam int EW = SEQ_WIDTH + WORD_WIDTH;

  pack_state_t            state;
  pack_state_t            next_state;

  logic [CW-1:0]          bit_cnt;
  logic [WORD_WIDTH-2:0]  sr;
  logic [SEQ_WIDTH-1:0]   seq_cnt;

  logic                   clear_partial;
  logic                   chip_take;
  logic                   word_done;
  logic [WORD_WIDTH-1:0]  word_next;

  logic [EW-1:0]          push_entry;
  logic [EW-1:0]          head_entry;
  logic                   fifo_empty;
  logic                   push_dropped;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: start (re)enters PACK and beats a simultaneous stop.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = PACK;
        end
      end
      PACK: begin
        if (start) begin
          next_state = PACK;
        end else if (stop) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control outputs: which chips are accepted and when the partial word is abandoned.
  always_comb begin
    busy          = (state == PACK);
    clear_partial = start || ((state == PACK) && stop);
    chip_take     = (state == PACK) && chip_vld && !start && !stop;
    word_done     = chip_take && (bit_cnt == CW'(WORD_WIDTH - 1));
    word_next     = {sr, chip_in};
    push_entry    = {seq_cnt, word_next};
  end

  // Shift register, bit counter and sequence counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      sr      <= '0;
      seq_cnt <= '0;
    end else begin
      if (clear_partial) begin
        bit_cnt <= '0;
        sr      <= '0;
      end else if (chip_take) begin
        sr      <= word_next[WORD_WIDTH-2:0];
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (start) begin
        seq_cnt <= '0;
      end else if (word_done) begin
        seq_cnt <= seq_cnt + 1'b1;
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_dropped) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  pcode_word_fifo #(
    .DATA_WIDTH (EW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_done),
    .push_data (push_entry),
    .pop       (word_ready),
    .pop_data  (head_entry),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .dropped   (push_dropped)
  );

  // Split the head entry back into sequence tag and word.
  always_comb begin
    word_valid = !fifo_empty;
    word_seq   = head_entry[EW-1:WORD_WIDTH];
    word_data  = head_entry[WORD_WIDTH-1:0];
  end

endmodule

// File: tb/tb_pcode_word_packer.sv
// Directed bench for the P-code word packer with WORD_WIDTH=8, FIFO_DEPTH=4,
// SEQ_WIDTH=4: a cycle-by-cycle vector table for the basic and gapped
// packing flows, then hand-written sequences for backpressure, overflow,
// restart/stop, reset and sequence wrap.
module tb_pcode_word_packer;

  localparam int WW = 8;
  localparam int FD = 4;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          chip_in;
  logic          chip_vld;
  logic [WW-1:0] word_data;
  logic [SW-1:0] word_seq;
  logic          word_valid;
  logic          word_ready;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          clr_ovf;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst, start, stop, chip, vld, ready, clr;
    logic       ev;
    logic [7:0] ed;
    logic [3:0] es;
    logic [2:0] el;
    logic       eo, eb;
  } vec_t;

  vec_t vecs[$];

  pcode_word_packer #(
    .WORD_WIDTH (WW),
    .FIFO_DEPTH (FD),
    .SEQ_WIDTH  (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .chip_in    (chip_in),
    .chip_vld   (chip_vld),
    .word_data  (word_data),
    .word_seq   (word_seq),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [7:0] ed,
                             input logic [3:0] es, input logic [2:0] el,
                             input logic eo, input logic eb);
    check({tag, ".word_valid"}, 32'(word_valid), 32'(ev));
    check({tag, ".word_data"},  32'(word_data),  32'(ed));
    check({tag, ".word_seq"},   32'(word_seq),   32'(es));
    check({tag, ".fifo_level"}, 32'(fifo_level), 32'(el));
    check({tag, ".overflow"},   32'(overflow),   32'(eo));
    check({tag, ".busy"},       32'(busy),       32'(eb));
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic c,
                               input logic v, input logic rd, input logic cl);
    rst = r; start = s; stop = p; chip_in = c; chip_vld = v; word_ready = rd; clr_ovf = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic chip_cycle(input logic c, input logic v, input logic rd);
    applyStimulus(1'b0, 1'b0, 1'b0, c, v, rd, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rd);
    for (int i = 7; i >= 0; i--) chip_cycle(w[i], 1'b1, rd);
  endtask

  task automatic add_vec(input logic r, input logic s, input logic p, input logic c,
                         input logic v, input logic rd, input logic cl,
                         input logic ev, input logic [7:0] ed, input logic [3:0] es,
                         input logic [2:0] el, input logic eo, input logic eb);
    vec_t x;
    x.rst = r; x.start = s; x.stop = p; x.chip = c; x.vld = v; x.ready = rd; x.clr = cl;
    x.ev = ev; x.ed = ed; x.es = es; x.el = el; x.eo = eo; x.eb = eb;
    vecs.push_back(x);
  endtask

  initial begin
    logic [7:0] w_b2;
    logic [7:0] w_3c;
    w_b2 = 8'hB2;
    w_3c = 8'h3C;
    rst = 1'b1; start = 0; stop = 0; chip_in = 0; chip_vld = 0; word_ready = 0; clr_ovf = 0;

    // ---------------- vector table ----------------
    add_vec(1,0,0,0,0,0,0, 0,8'h00,0,0,0,0);            // reset
    add_vec(0,0,0,1,1,1,0, 0,8'h00,0,0,0,0);            // idle ignores chips
    add_vec(0,1,0,0,0,1,0, 0,8'h00,0,0,0,1);            // start
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) add_vec(0,0,0,w_b2[i],1,1,0, 1,8'hB2,0,1,0,1);
      else        add_vec(0,0,0,w_b2[i],1,1,0, 0,8'h00,0,0,0,1);
    end
    add_vec(0,0,0,0,0,1,0, 0,8'h00,0,0,0,1);            // popped after one cycle
    add_vec(0,1,0,0,0,1,0, 0,8'h00,0,0,0,1);            // restart, seq back to 0
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) add_vec(0,0,0,w_b2[i],1,1,0, 1,8'hB2,0,1,0,1);
      else        add_vec(0,0,0,w_b2[i],1,1,0, 0,8'h00,0,0,0,1);
      add_vec(0,0,0,~w_b2[i],0,1,0, 0,8'h00,0,0,0,1);   // gap cycle, junk chip
    end
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) add_vec(0,0,0,w_3c[i],1,1,0, 1,8'h3C,1,1,0,1);
      else        add_vec(0,0,0,w_3c[i],1,1,0, 0,8'h00,0,0,0,1);
    end
    add_vec(0,0,0,0,0,1,0, 0,8'h00,0,0,0,1);
    add_vec(0,0,1,0,0,1,0, 0,8'h00,0,0,0,0);            // stop

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].chip,
                    vecs[i].vld, vecs[i].ready, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].es,
                  vecs[i].el, vecs[i].eo, vecs[i].eb);
    end

    // ---------------- backpressure and overflow ----------------
    applyStimulus(1,0,0,0,0,0,0);
    applyStimulus(0,1,0,0,0,0,0);
    for (int k = 1; k <= 4; k++) begin
      send_word(8'hFF, 1'b0);
      checkOutput($sformatf("bp_word%0d", k), 1, 8'hFF, 0, 3'(k), 0, 1);
    end
    send_word(8'hFF, 1'b0);
    checkOutput("bp_drop", 1, 8'hFF, 0, 4, 1, 1);
    for (int k = 0; k < 4; k++) begin
      word_ready = 1'b1;
      check($sformatf("bp_pop%0d.seq", k), 32'(word_seq), 32'(k));
      check($sformatf("bp_pop%0d.valid", k), 32'(word_valid), 32'd1);
      chip_cycle(1'b0, 1'b0, 1'b1);
    end
    checkOutput("bp_drained", 0, 8'h00, 0, 0, 1, 1);
    send_word(8'h96, 1'b0);
    checkOutput("bp_gap_seq", 1, 8'h96, 5, 1, 1, 1);
    applyStimulus(0,0,0,0,0,0,1);
    checkOutput("clr_ovf", 1, 8'h96, 5, 1, 0, 1);

    // full FIFO with pop in the push cycle
    for (int k = 0; k < 3; k++) send_word(8'h11, 1'b0);
    checkOutput("full4", 1, 8'h96, 5, 4, 0, 1);
    for (int i = 7; i >= 1; i--) chip_cycle(1'b0, 1'b1, 1'b0);
    chip_cycle(1'b1, 1'b1, 1'b1);
    checkOutput("full_push_pop", 1, 8'h11, 6, 4, 0, 1);

    // drop and clear in the same cycle: set wins
    for (int i = 7; i >= 1; i--) chip_cycle(1'b0, 1'b1, 1'b0);
    applyStimulus(0,0,0,1,1,0,1);
    checkOutput("drop_vs_clr", 1, 8'h11, 6, 4, 1, 1);

    // ---------------- restart / stop ----------------
    applyStimulus(1,0,0,0,0,0,0);
    checkOutput("rst_full", 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(0,1,0,0,0,0,0);
    for (int i = 0; i < 5; i++) chip_cycle(1'b1, 1'b1, 1'b0);
    applyStimulus(0,1,0,1,1,0,0);                        // chip with start is discarded
    send_word(8'h5A, 1'b0);
    checkOutput("restart_word", 1, 8'h5A, 0, 1, 0, 1);
    chip_cycle(1'b0, 1'b0, 1'b1);
    checkOutput("restart_only_one", 0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) chip_cycle(1'b1, 1'b1, 1'b0);
    applyStimulus(0,0,1,1,1,0,0);
    checkOutput("stop_idle", 0, 8'h00, 0, 0, 0, 0);
    send_word(8'h5A, 1'b0);
    checkOutput("stop_ignores", 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(0,1,1,0,0,0,0);
    checkOutput("start_beats_stop", 0, 8'h00, 0, 0, 0, 1);
    send_word(8'hA5, 1'b0);
    checkOutput("after_stop_word", 1, 8'hA5, 0, 1, 0, 1);

    // ---------------- reset mid-operation ----------------
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) chip_cycle(1'b1, 1'b1, 1'b0);
    checkOutput("three_words", 1, 8'hA5, 0, 3, 0, 1);
    applyStimulus(1,0,0,1,1,0,0);
    checkOutput("rst_mid", 0, 8'h00, 0, 0, 0, 0);

    // ---------------- sequence wrap ----------------
    applyStimulus(0,1,0,0,0,1,0);
    for (int k = 0; k < 17; k++) begin
      send_word(8'hC3, 1'b1);
      checkOutput($sformatf("wrap%0d", k), 1, 8'hC3, 4'(k % 16), 1, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
